// File: rtl/mips_pkg.sv
// Shared encodings for the branch predictor: 2-bit saturating counter states.
package mips_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt2_t;

    localparam cnt2_t CNT_RESET = WNT;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/Decode-side signals of the branch predictor; master is the pipeline, slave the predictor.
interface branch_predictor_if;
    logic [31:0] PCF;
    logic        StallD;
    logic        FlushD;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic [31:0] PCD;
    logic        IsBranchD;
    logic        BranchD;
    logic [31:0] PCBranchD;
    logic        MistakeD;
    logic [31:0] BranchCnt;
    logic [31:0] MispredCnt;

    modport master (
        output PCF, StallD, FlushD, PCD, IsBranchD, BranchD, PCBranchD, MistakeD,
        input  PredTakenF, PredTargetF, BranchCnt, MispredCnt
    );

    modport slave (
        input  PCF, StallD, FlushD, PCD, IsBranchD, BranchD, PCBranchD, MistakeD,
        output PredTakenF, PredTargetF, BranchCnt, MispredCnt
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
module sat_counter2
    import mips_pkg::*;
(
    input  cnt2_t cnt_i,
    input  logic  taken_i,
    output cnt2_t cnt_o
);
    always_comb begin
        cnt_o = cnt_i;
        case (cnt_i)
            SNT:     cnt_o = taken_i ? WNT : SNT;
            WNT:     cnt_o = taken_i ? WT  : SNT;
            WT:      cnt_o = taken_i ? ST  : WNT;
            ST:      cnt_o = taken_i ? ST  : WT;
            default: cnt_o = CNT_RESET;
        endcase
    end
endmodule

// File: rtl/branch_predictor.sv
// gshare BHT + direct-mapped BTB predictor; trains from the Decode-stage resolution report.
module branch_predictor
    import mips_pkg::*;
#(
    parameter int IDX_BITS = 6,
    parameter int GHR_BITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    branch_predictor_if.slave  bp
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 30 - IDX_BITS;

    cnt2_t                bht_q     [ENTRIES];
    logic [ENTRIES-1:0]   btb_vld_q;
    logic [TAG_W-1:0]     btb_tag_q [ENTRIES];
    logic [31:0]          btb_tgt_q [ENTRIES];
    logic [GHR_BITS-1:0]  ghr_q, ghr_d;
    logic [IDX_BITS-1:0]  idx_d_q;
    logic                 valid_d_q;
    logic [31:0]          branch_cnt_q, branch_cnt_d;
    logic [31:0]          mispred_cnt_q, mispred_cnt_d;

    logic [IDX_BITS-1:0]  btb_idx_f, idx_f, btb_idx_d;
    logic                 hit_f, upd;
    cnt2_t                cnt_upd;
    logic                 unused_pc_lsbs;

    assign btb_idx_f = bp.PCF[IDX_BITS+1:2];
    assign idx_f     = btb_idx_f ^ IDX_BITS'(ghr_q);
    assign btb_idx_d = bp.PCD[IDX_BITS+1:2];
    assign unused_pc_lsbs = ^{bp.PCF[1:0], bp.PCD[1:0]};

    // Reads see pre-update array contents; no write-to-read bypass.
    assign hit_f          = btb_vld_q[btb_idx_f] && (btb_tag_q[btb_idx_f] == bp.PCF[31:IDX_BITS+2]);
    assign bp.PredTakenF  = bht_q[idx_f][1] & hit_f;
    assign bp.PredTargetF = hit_f ? btb_tgt_q[btb_idx_f] : bp.PCF + 32'd4;
    assign bp.BranchCnt   = branch_cnt_q;
    assign bp.MispredCnt  = mispred_cnt_q;

    assign upd = bp.IsBranchD & valid_d_q & ~bp.StallD;

    sat_counter2 u_cnt (
        .cnt_i   (bht_q[idx_d_q]),
        .taken_i (bp.BranchD),
        .cnt_o   (cnt_upd)
    );

    always_comb begin
        ghr_d         = ghr_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd) begin
            ghr_d         = {ghr_q[GHR_BITS-2:0], bp.BranchD};
            branch_cnt_d  = branch_cnt_q + 32'd1;
            mispred_cnt_d = mispred_cnt_q + {31'd0, bp.MistakeD};
        end
    end

    // Training uses the index captured at fetch time, since GHR may move before resolve.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) bht_q[i] <= CNT_RESET;
            btb_vld_q     <= '0;
            ghr_q         <= '0;
            idx_d_q       <= '0;
            valid_d_q     <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (!bp.StallD) begin
                idx_d_q   <= idx_f;
                valid_d_q <= ~bp.FlushD;
            end
            if (upd) begin
                bht_q[idx_d_q] <= cnt_upd;
                if (bp.BranchD) btb_vld_q[btb_idx_d] <= 1'b1;
            end
            ghr_q         <= ghr_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && upd && bp.BranchD) begin
            btb_tag_q[btb_idx_d] <= bp.PCD[31:IDX_BITS+2];
            btb_tgt_q[btb_idx_d] <= bp.PCBranchD;
        end
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side predictor that generates the taken/not-taken guess the Decode stage checks.
- Decode resolves each branch and reports IsBranchD, BranchD, PCBranchD and MistakeD back to this block, which trains its tables on that report.
- Structure: gshare BHT of 2-bit counters, plus a direct-mapped BTB supplying the target.
- Sits beside the PC register in Fetch.

Parameters:
- IDX_BITS, 6, log2 of BHT and BTB entries (64 each).
- GHR_BITS, 4, global history length. Must be <= IDX_BITS.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- PCF  in  32  fetch PC.
- StallD  in  1  Decode stage holding; fetch slot does not advance.
- FlushD  in  1  Decode slot is being flushed.
- PredTakenF  out  1  prediction for PCF; registered into the Decode stage as BranchDIn.
- PredTargetF  out  32  predicted target. Valid only when PredTakenF=1.
- PCD  in  32  PC of the instruction in Decode.
- IsBranchD  in  1  Decode holds a conditional branch.
- BranchD  in  1  resolved outcome, 1 = taken.
- PCBranchD  in  32  resolved taken target.
- MistakeD  in  1  prediction mismatch flag from Decode.
- BranchCnt  out  32  branches retired from Decode.
- MispredCnt  out  32  mispredictions.

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high.
  - Reset clears: all BHT counters to 01 (weakly not-taken), all BTB valid bits, GHR, idxD, validD, BranchCnt and MispredCnt.
  - An update presented in the reset cycle is discarded.
  - After reset, PredTakenF=0 for every PC.
- Fetch index: idxF = PCF[IDX_BITS+1:2] XOR zero-extended GHR.
- Prediction (combinational from register arrays, 0-cycle latency):
  - PredTakenF = BHT[idxF][1] AND BTB hit.
  - BTB hit = valid[PCF[IDX_BITS+1:2]] AND tag equals PCF[31:IDX_BITS+2].
  - PredTargetF = BTB target at that index. When there is no hit, PredTargetF = PCF+4.
- Pipeline alignment:
  - On each edge with StallD=0: idxD <= idxF and validD <= ~FlushD.
  - On edges with StallD=1: both hold.
  - Reason: GHR can change between fetch and resolve, so training must use the fetch-time index, not a recomputed one.
- Update condition: upd = IsBranchD & validD & ~StallD. A stalled branch trains exactly once, on the cycle it leaves Decode.
- On upd, at the same edge:
  - BHT[idxD]: saturating increment if BranchD, otherwise decrement. 11 stays 11 on taken; 00 stays 00 on not-taken.
  - GHR <= {GHR[GHR_BITS-2:0], BranchD}.
  - If BranchD: the BTB entry at PCD index gets valid=1, tag=PCD[31:IDX_BITS+2], target=PCBranchD. This overwrites on conflict.
  - If not BranchD: BTB unchanged.
  - BranchCnt += 1. MispredCnt += MistakeD. Both wrap modulo 2^32.
- Simultaneous read/write of the same BHT or BTB entry: the read sees the pre-update value. No bypass.
- FlushD together with StallD=0: the next Decode slot is invalid. A branch arriving there does not train or count.
- Reset asserted mid-stall or mid-update: reset wins and all state returns to reset values.

Decomposition:
- Shared package (mips_pkg): 2-bit counter encodings (SNT=00, WNT=01, WT=10, ST=11) and the constant CNT_RESET=WNT.
- One sub-module: sat_counter2 (2-bit saturating next-state function, combinational). Instantiate it once on the update path.
- BHT, BTB and GHR stay in the top module as register arrays.

Test Plan:
- Reset: assert reset 2 cycles, then PCF=0x00400010 -> PredTakenF=0, PredTargetF=0x00400014, BranchCnt=0, MispredCnt=0.
- Loop training: branch at PCD=0x00400020, target 0x00400008, resolved taken twice with GHR_BITS forced 0-effect (same history), MistakeD=1 then 0 -> BHT entry 01->10->11. Fetch of 0x00400020 then gives PredTakenF=1, PredTargetF=0x00400008. BranchCnt=2, MispredCnt=1.
- Saturation: three further taken updates -> counter stays 11. One not-taken -> 10, still predicts taken. Second not-taken -> 01, PredTakenF=0 with the BTB entry still valid.
- Stall: IsBranchD=1 with StallD=1 for 3 cycles, then StallD=0 -> exactly one counter step and BranchCnt +1.
- Flush: FlushD=1 on the edge a branch enters Decode, then IsBranchD=1 -> no BHT/BTB/GHR/counter change.
- Same-entry hazard: update entry k taken while PCF maps to k in the same cycle -> PredTakenF reflects the old counter. The next cycle reflects the new one.
